// File: rtl/bus_pkg.sv
// Shared bus types: arbitration mode, CPU-side bus address and region decode.
package bus_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_t;

   typedef logic [15:0] bus_addr_t;

   typedef enum logic [1:0] {
      REGION_WRAM = 2'd0,
      REGION_VRAM = 2'd1,
      REGION_IO   = 2'd2,
      REGION_ROM  = 2'd3
   } region_t;

   // Coarse 16 KiB region decode of a CPU bus address.
   function automatic region_t decode_region(input bus_addr_t a);
      return region_t'(a[15:14]);
   endfunction

   // Map the integer ROUND_ROBIN parameter onto the arbitration mode.
   function automatic arb_mode_t arb_mode(input int round_robin);
      return (round_robin != 0) ? ARB_RR : ARB_FIXED;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: fixed priority (lowest index) or round-robin starting after
// the last winner. Owns the round-robin pointer.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int N           = 3,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         eligible,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 grant_valid
);

   localparam int        IDX_W = $clog2(N);
   localparam arb_mode_t MODE  = arb_mode(ROUND_ROBIN);

   typedef logic [IDX_W-1:0] idx_t;

   idx_t ptr;
   idx_t cand;

   // Pick the winner among eligible ports for this cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      if (MODE == ARB_FIXED) begin
         for (int i = 0; i < N; i++) begin
            if (!grant_valid && eligible[i]) begin
               grant_idx   = idx_t'(i);
               grant_valid = 1'b1;
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            cand = idx_t'((int'(ptr) + k) % N);
            if (!grant_valid && eligible[cand]) begin
               grant_idx   = cand;
               grant_valid = 1'b1;
            end
         end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;
   end

   // Remember the last winner; the search restarts just after it.
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
      if (rst)              ptr <= idx_t'(N - 1);
      else if (grant_valid) ptr <= grant_idx;
   end

endmodule

// File: rtl/multiport_ram.sv
// Shared single-port synchronous RAM behind an N-requestor arbiter.
// One access per clock, req/ack handshake per port, read latency 1.
module multiport_ram
   import bus_pkg::*;
#(
   parameter int NUM_PORTS   = 3,
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          port_en,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          ack,
   output logic [NUM_PORTS*DATA_W-1:0]   rdata,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic [DATA_W-1:0]    rdata_q [NUM_PORTS];

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_valid;
   logic                 g_we;
   logic [ADDR_W-1:0]    g_addr;
   logic [DATA_W-1:0]    g_wdata;

   // A port being acked this cycle is masked so its next request is not double-counted.
   assign eligible = req & port_en & ~ack;

   rr_arbiter #(
      .N           (NUM_PORTS),
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .eligible    (eligible),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Route the winning port's command onto the single RAM port.
   always_comb begin
      g_we    = we[grant_idx];
      g_addr  = addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      g_wdata = wdata[int'(grant_idx)*DATA_W +: DATA_W];
   end

   // RAM write port; a reset cycle suppresses the granted write.
   always_ff @(posedge clk) begin
      // NOTE: the array itself has no reset, so it can map onto a block RAM.
      if (!rst && grant_valid && g_we) mem[g_addr] <= g_wdata;
   end

   // Handshake, busy flag and per-port read data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack  <= '0;
         busy <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
      end else begin
         ack  <= grant;
         busy <= grant_valid;
         if (grant_valid && !g_we) rdata_q[grant_idx] <= mem[g_addr];
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign rdata[i*DATA_W +: DATA_W] = rdata_q[i];

      // A pending request must stay up until its ack arrives.
      a_req_held : assert property (@(posedge clk) disable iff (rst)
         (!$past(rst) && $past(req[i]) && !$past(ack[i])) |-> (req[i] || ack[i]));
   end

endmodule

// File: tb/tb_multiport_ram.sv
// Directed bench for multiport_ram: one fixed-priority and one round-robin instance.
module tb_multiport_ram;

   localparam int NP = 3;
   localparam int AW = 13;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     port_en;
   logic [NP-1:0]     req_f, req_r, we;
   logic [NP*AW-1:0]  addr;
   logic [NP*DW-1:0]  wdata;
   logic [NP-1:0]     ack_f, ack_r;
   logic [NP*DW-1:0]  rdata_f, rdata_r;
   logic              busy_f, busy_r;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multiport_ram #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)) u_fix (
      .clk(clk), .rst(rst), .port_en(port_en), .req(req_f), .we(we), .addr(addr),
      .wdata(wdata), .ack(ack_f), .rdata(rdata_f), .busy(busy_f));

   multiport_ram #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst(rst), .port_en(port_en), .req(req_r), .we(we), .addr(addr),
      .wdata(wdata), .ack(ack_r), .rdata(rdata_r), .busy(busy_r));

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[p] = w;
      addr[p*AW +: AW] = a;
      wdata[p*DW +: DW] = d;
   endtask

   function automatic logic [DW-1:0] lane(input logic [NP*DW-1:0] v, input int p);
      return v[p*DW +: DW];
   endfunction

   task automatic test_reset();
      rst = 1'b1; port_en = '1; req_f = '0; req_r = '0; we = '0; addr = '0; wdata = '0;
      tick(); tick();
      total++; if (ack_f !== 3'b000)  begin bad++; $display("FAIL reset_ack_f: got %b want 000", ack_f); end
      total++; if (busy_f !== 1'b0)   begin bad++; $display("FAIL reset_busy_f: got %b want 0", busy_f); end
      total++; if (rdata_f !== '0)    begin bad++; $display("FAIL reset_rdata_f: got %h want 0", rdata_f); end
      total++; if (ack_r !== 3'b000)  begin bad++; $display("FAIL reset_ack_r: got %b want 000", ack_r); end
      total++; if (busy_r !== 1'b0)   begin bad++; $display("FAIL reset_busy_r: got %b want 0", busy_r); end
      total++; if (rdata_r !== '0)    begin bad++; $display("FAIL reset_rdata_r: got %h want 0", rdata_r); end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      set_port(0, 1'b1, 13'h1234, 8'hA5); req_f[0] = 1'b1;
      tick();
      total++; if (ack_f !== 3'b001) begin bad++; $display("FAIL wr_ack: got %b want 001", ack_f); end
      total++; if (busy_f !== 1'b1)  begin bad++; $display("FAIL wr_busy: got %b want 1", busy_f); end
      req_f[0] = 1'b0;
      tick();
      total++; if (ack_f !== 3'b000) begin bad++; $display("FAIL wr_idle_ack: got %b want 000", ack_f); end
      total++; if (busy_f !== 1'b0)  begin bad++; $display("FAIL wr_idle_busy: got %b want 0", busy_f); end
      set_port(0, 1'b0, 13'h1234, 8'h00); req_f[0] = 1'b1;
      tick();
      total++; if (ack_f !== 3'b001) begin bad++; $display("FAIL rd_ack: got %b want 001", ack_f); end
      total++; if (lane(rdata_f, 0) !== 8'hA5) begin bad++; $display("FAIL rd_data: got %h want a5", lane(rdata_f, 0)); end
      req_f[0] = 1'b0;
      tick();
      total++; if (lane(rdata_f, 0) !== 8'hA5) begin bad++; $display("FAIL rd_hold: got %h want a5", lane(rdata_f, 0)); end
   endtask

   task automatic test_fixed_order();
      logic [NP-1:0] exp_a [4];
      logic [NP-1:0] exp_b [5];
      logic [NP-1:0] drop;
      int n0;
      exp_a = '{3'b001, 3'b010, 3'b100, 3'b000};
      exp_b = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b000};
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, 13'h1234, 8'h00);
      req_f = 3'b111;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (ack_f !== exp_a[c]) begin bad++; $display("FAIL fix_order c%0d: got %b want %b", c, ack_f, exp_a[c]); end
         for (int p = 0; p < NP; p++) if (ack_f[p]) begin
            total++; if (lane(rdata_f, p) !== 8'hA5) begin bad++; $display("FAIL fix_data p%0d: got %h want a5", p, lane(rdata_f, p)); end
         end
         req_f = req_f & ~ack_f;
      end
      // Port 0 re-requests as soon as its first ack arrives.
      req_f = 3'b111; n0 = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if (ack_f !== exp_b[c]) begin bad++; $display("FAIL fix_rereq c%0d: got %b want %b", c, ack_f, exp_b[c]); end
         drop = ack_f;
         if (ack_f[0] && n0 == 0) drop[0] = 1'b0;
         if (ack_f[0]) n0++;
         req_f = req_f & ~drop;
      end
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] exp_v;
      int last [NP];
      int max_gap;
      for (int p = 0; p < NP; p++) begin set_port(p, 1'b0, 13'h0100, 8'h00); last[p] = 0; end
      max_gap = 0;
      req_r = 3'b111;
      for (int c = 1; c <= 10; c++) begin
         tick();
         exp_v = (c == 10) ? 3'b000 : (3'b001 << ((c - 1) % 3));
         total++; if (ack_r !== exp_v) begin bad++; $display("FAIL rr_order c%0d: got %b want %b", c, ack_r, exp_v); end
         if (c <= 9) begin
            for (int p = 0; p < NP; p++) if (ack_r[p]) begin
               if (c - last[p] > max_gap) max_gap = c - last[p];
               last[p] = c;
            end
         end
         if (c >= 7) req_r = req_r & ~ack_r;
      end
      total++; if (max_gap > 3 || max_gap == 0) begin bad++; $display("FAIL rr_starve: got gap %0d want 1..3", max_gap); end
   endtask

   task automatic test_port_en();
      bit got;
      port_en[1] = 1'b0;
      set_port(1, 1'b0, 13'h1234, 8'h00); req_f[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++; if (ack_f[1] !== 1'b0) begin bad++; $display("FAIL en_lockout c%0d: got %b want 0", c, ack_f[1]); end
      end
      port_en[1] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 2 && !got; c++) begin
         tick();
         if (ack_f[1] === 1'b1) got = 1'b1;
      end
      total++; if (!got) begin bad++; $display("FAIL en_release: got no ack want ack within 2 cycles"); end
      total++; if (lane(rdata_f, 1) !== 8'hA5) begin bad++; $display("FAIL en_data: got %h want a5", lane(rdata_f, 1)); end
      req_f[1] = 1'b0;
      tick();
   endtask

   task automatic test_collision();
      set_port(2, 1'b1, 13'h0010, 8'h77); req_f[2] = 1'b1;
      tick();
      total++; if (ack_f !== 3'b100) begin bad++; $display("FAIL col_seed: got %b want 100", ack_f); end
      req_f[2] = 1'b0;
      tick();
      set_port(0, 1'b0, 13'h0010, 8'h00);
      set_port(1, 1'b1, 13'h0010, 8'h3C);
      req_f = 3'b011;
      tick();
      total++; if (ack_f !== 3'b001) begin bad++; $display("FAIL col_ack0: got %b want 001", ack_f); end
      total++; if (lane(rdata_f, 0) !== 8'h77) begin bad++; $display("FAIL col_old: got %h want 77", lane(rdata_f, 0)); end
      tick();
      total++; if (ack_f !== 3'b010) begin bad++; $display("FAIL col_ack1: got %b want 010", ack_f); end
      total++; if (lane(rdata_f, 1) !== 8'hA5) begin bad++; $display("FAIL col_wr_keep: got %h want a5", lane(rdata_f, 1)); end
      req_f[1] = 1'b0;
      tick();
      total++; if (ack_f !== 3'b001) begin bad++; $display("FAIL col_ack0b: got %b want 001", ack_f); end
      total++; if (lane(rdata_f, 0) !== 8'h3C) begin bad++; $display("FAIL col_new: got %h want 3c", lane(rdata_f, 0)); end
      req_f[0] = 1'b0;
      tick();
   endtask

   task automatic test_reset_write();
      set_port(0, 1'b1, 13'h0010, 8'hEE); req_f[0] = 1'b1; rst = 1'b1;
      tick();
      total++; if (ack_f !== 3'b000) begin bad++; $display("FAIL rstw_ack: got %b want 000", ack_f); end
      total++; if (busy_f !== 1'b0)  begin bad++; $display("FAIL rstw_busy: got %b want 0", busy_f); end
      total++; if (rdata_f !== '0)   begin bad++; $display("FAIL rstw_rdata: got %h want 0", rdata_f); end
      rst = 1'b0; req_f[0] = 1'b0;
      tick();
      total++; if (ack_f !== 3'b000) begin bad++; $display("FAIL rstw_forgot: got %b want 000", ack_f); end
      set_port(0, 1'b0, 13'h0010, 8'h00); req_f[0] = 1'b1;
      tick();
      total++; if (ack_f !== 3'b001) begin bad++; $display("FAIL rstw_rd_ack: got %b want 001", ack_f); end
      total++; if (lane(rdata_f, 0) !== 8'h3C) begin bad++; $display("FAIL rstw_keep: got %h want 3c", lane(rdata_f, 0)); end
      req_f[0] = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fixed_order();
      test_round_robin();
      test_port_en();
      test_collision();
      test_reset_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
